// File: rtl/ex_muldiv_unit_if.sv
// HI/LO instruction bus between the ID/EX pipeline register and the EX-stage multiply/divide unit.
// The master drives the EX instruction fields and the slave returns HI/LO, mf_data and the stall request.
interface ex_muldiv_unit_if;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;
  logic        busy;
  logic        stall;

  modport master (
    output op_valid, funct, rs, rt,
    input  hi, lo, mf_data, busy, stall
  );

  modport slave (
    input  op_valid, funct, rs, rt,
    output hi, lo, mf_data, busy, stall
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit that owns HI/LO: a shift-add multiply and a restoring divide, each 33 cycles.
// Define MULDIV_DIV_EN to build the divider; without it, DIV/DIVU issued in IDLE are treated as no-ops.
module ex_muldiv_unit (
  input  logic           clk,
  input  logic           reset,
  ex_muldiv_unit_if.slave bus
);
  localparam int DATA_W = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  function automatic logic [DATA_W-1:0] abs32(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  state_e state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     mul_sum;
`ifdef MULDIV_DIV_EN
  logic                op_div_q, op_div_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [DATA_W+1:0]   div_shift;
  logic [DATA_W+1:0]   div_diff;
  logic                div_ge;
  logic                div_zero;
`endif

  logic is_mul, is_div, is_hilo, signed_op, start_mul, start_div, start;

  assign is_mul    = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign is_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign is_hilo   = is_mul || is_div || (bus.funct == F_MFHI) || (bus.funct == F_MTHI) ||
                     (bus.funct == F_MFLO) || (bus.funct == F_MTLO);
  assign signed_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign start_mul = (state_q == S_IDLE) && bus.op_valid && is_mul;
`ifdef MULDIV_DIV_EN
  assign start_div = (state_q == S_IDLE) && bus.op_valid && is_div;
`else
  assign start_div = 1'b0;
`endif
  assign start     = start_mul || start_div;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.stall   = bus.busy && bus.op_valid && is_hilo;
    bus.mf_data = (bus.funct == F_MFHI) ? hi_q : lo_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
  end

  // Iteration and result datapath
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    prod      = cond_neg64(acc_q, neg_res_q);
`ifdef MULDIV_DIV_EN
    op_div_d  = op_div_q;
    rem_d     = rem_q;
    div_shift = {rem_q, acc_q[DATA_W-1]};
    div_diff  = div_shift - {2'b00, opb_q};
    div_ge    = (div_shift >= {2'b00, opb_q});
    div_zero  = (bus.rt == 32'd0);
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid && bus.funct == F_MTHI) hi_d = bus.rs;
        if (bus.op_valid && bus.funct == F_MTLO) lo_d = bus.rs;
        if (start_mul) begin
          cnt_d     = 5'd0;
          opb_d     = signed_op ? abs32(bus.rs) : bus.rs;
          acc_d     = {32'd0, (signed_op ? abs32(bus.rt) : bus.rt)};
          neg_res_d = signed_op && (bus.rs[DATA_W-1] ^ bus.rt[DATA_W-1]);
          neg_rem_d = 1'b0;
`ifdef MULDIV_DIV_EN
          op_div_d  = 1'b0;
`endif
        end
`ifdef MULDIV_DIV_EN
        // A zero divisor keeps the raw dividend so the divide naturally leaves quotient all-ones and remainder rs
        if (start_div) begin
          cnt_d     = 5'd0;
          opb_d     = signed_op ? abs32(bus.rt) : bus.rt;
          acc_d     = {32'd0, ((signed_op && !div_zero) ? abs32(bus.rs) : bus.rs)};
          rem_d     = 33'd0;
          neg_res_d = signed_op && !div_zero && (bus.rs[DATA_W-1] ^ bus.rt[DATA_W-1]);
          neg_rem_d = signed_op && !div_zero && bus.rs[DATA_W-1];
          op_div_d  = 1'b1;
        end
`endif
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        if (op_div_q) begin
          rem_d = 33'(div_ge ? div_diff : div_shift);
          acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
`else
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
`endif
      end
      S_FIX: begin
`ifdef MULDIV_DIV_EN
        if (op_div_q) begin
          lo_d = cond_neg32(acc_q[DATA_W-1:0], neg_res_q);
          hi_d = cond_neg32(rem_q[DATA_W-1:0], neg_rem_q);
        end else begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
`else
        hi_d = prod[2*DATA_W-1:DATA_W];
        lo_d = prod[DATA_W-1:0];
`endif
      end
      default: ;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q  <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`ifdef MULDIV_DIV_EN
      op_div_q  <= op_div_d;
`endif
    end
  end

  // Operand and accumulator registers
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    opb_q <= opb_d;
`ifdef MULDIV_DIV_EN
    rem_q <= rem_d;
`endif
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of mul/div vectors through a result scoreboard, plus
// hand sequences for moves, stall timing, reset mid-operation and the divider-disabled build.
module tb_ex_muldiv_unit;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.funct    = 6'h00;
    bus.rs       = 32'd0;
    bus.rt       = 32'd0;
  endtask

  // Issues one mul/div, waits (bounded) for busy to fall and checks latency and scoreboard result
  task automatic run_vec(input vec_t v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct    = v.funct;
    bus.rs       = v.rs;
    bus.rt       = v.rt;
    sb_q.push_back('{v.name, v.hi, v.lo});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check({v.name, " busy_start"}, {31'd0, bus.busy}, 32'd1);
    cyc = 1;
    while (bus.busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, " latency"}, cyc, 32'd34);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", v.name);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " hi"}, bus.hi, e.hi);
      check({e.name, " lo"}, bus.lo, e.lo);
    end
  endtask

  task automatic move(input logic [5:0] f, input logic [31:0] val);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.rs       = val;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;

    vecs.push_back('{"mult_neg3x5",   F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"multu_neg3x5",  F_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1});
    vecs.push_back('{"mult_min_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"multu_max_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_m1xm1",    F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{"divu_100_7",    F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{"div_m7_2",      F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_7_m2",      F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"div_by_zero",   F_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF});
    vecs.push_back('{"div_zero_neg",  F_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF});
    vecs.push_back('{"divu_by_zero",  F_DIVU,  32'h80000001, 32'd0,        32'h80000001, 32'hFFFFFFFF});
    vecs.push_back('{"div_overflow",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"divu_max_16",   F_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset stall", {31'd0, bus.stall}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MTHI/MTLO followed directly by MFHI/MFLO, never stalling
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct    = F_MTHI;
    bus.rs       = 32'hA5A5A5A5;
    #1 check("mthi stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.funct = F_MFHI;
    bus.rs    = 32'd0;
    #1 check("mfhi data", bus.mf_data, 32'hA5A5A5A5);
    check("mfhi stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.funct = F_MTLO;
    bus.rs    = 32'h5A5A1234;
    @(negedge clk);
    bus.funct = F_MFLO;
    bus.rs    = 32'd0;
    #1 check("mflo data", bus.mf_data, 32'h5A5A1234);
    check("mtlo keeps hi", bus.hi, 32'hA5A5A5A5);

    // MULT 6*7, unknown funct while busy, then MFLO held under stall
    @(negedge clk);
    bus.funct = F_MULT;
    bus.rs    = 32'd6;
    bus.rt    = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.funct = 6'h20;
    bus.rs    = 32'd0;
    bus.rt    = 32'd0;
    #1 check("unknown funct stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.funct = F_MFLO;
    #1 n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mflo stall cycles", n, 32'd32);
    check("mflo after stall", bus.mf_data, 32'd42);
    check("mult6x7 hi", bus.hi, 32'd0);
    check("busy after stall", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    idle_inputs();

    // Pending DIVU while busy stalls in both builds; then reset mid-operation
    @(negedge clk);
    bus.op_valid = 1'b1;
`ifdef MULDIV_DIV_EN
    bus.funct = F_DIVU;
`else
    bus.funct = F_MULTU;
`endif
    bus.rs = 32'd1000;
    bus.rt = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.funct = F_DIVU;
    #1 check("div stalls while busy", {31'd0, bus.stall}, 32'd1);
    repeat (9) @(negedge clk);
    bus.op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    check("midop reset busy", {31'd0, bus.busy}, 32'd0);
    check("midop reset hi", bus.hi, 32'd0);
    check("midop reset lo", bus.lo, 32'd0);
    run_vec('{"mult_2x3", F_MULT, 32'd2, 32'd3, 32'd0, 32'd6});

`ifndef MULDIV_DIV_EN
    // Divider removed: DIVU in IDLE is a no-op
    move(F_MTHI, 32'h11112222);
    move(F_MTLO, 32'h33334444);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct    = F_DIVU;
    bus.rs       = 32'd100;
    bus.rt       = 32'd7;
    #1 check("nodiv stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    check("nodiv busy", {31'd0, bus.busy}, 32'd0);
    check("nodiv hi", bus.hi, 32'h11112222);
    check("nodiv lo", bus.lo, 32'h33334444);
`endif

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
